mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory stage of the sequential Y86-64 core; consumes execute outputs (icode, valE, valA) plus valP from fetch.
- Issues a single read or write transaction to the data memory over a req/ack handshake and returns valM and a memory-error flag.
- Instructions that need no memory access complete in one cycle.
- Sits between the execute stage and write-back/PC-update; the stage controller holds inputs stable while in_valid is high.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes; a valid access satisfies addr + 8 <= MEM_BYTES.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for mem_ack (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  execute results valid; inputs held stable until in_ready.
- in_ready  output  1  high in IDLE.
- icode  input  4  Y86 instruction code.
- valE  input  64  execute result.
- valA  input  64  register A value.
- valP  input  64  next sequential PC.
- mem_req  output  1  transaction request; held until mem_ack.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  64  byte address.
- mem_wdata  output  64  write data.
- mem_rdata  input  64  read data; valid when mem_ack is high.
- mem_ack  input  1  one-cycle completion pulse.
- out_valid  output  1  one-cycle pulse; result ready.
- valM  output  64  read data, or 0 for non-read instructions.
- dmem_error  output  1  address or timeout error, qualified by out_valid.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - state = IDLE.
  - mem_req, mem_we, out_valid, dmem_error = 0.
  - mem_addr, mem_wdata, valM = 0.
  - Reset mid-transaction aborts it; mem_req drops on the next edge; a late mem_ack is ignored.
- Decode, on accept (in_valid and in_ready):
  - rmmovq (4) and pushq (A): write, addr = valE, data = valA.
  - call (8): write, addr = valE, data = valP.
  - mrmovq (5): read, addr = valE.
  - popq (B) and ret (9): read, addr = valA.
  - All other icodes: no access.
- Address check: error if addr[2:0] != 0 or addr > MEM_BYTES - 8 (unsigned 64-bit compare).
- IDLE:
  - On accept with no access: go to DONE, valM = 0, dmem_error = 0.
  - On accept with access and address error: go to DONE, dmem_error = 1, no mem_req issued.
  - Otherwise: register addr, we and wdata, assert mem_req, go to WAIT.
- WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable.
  - On mem_ack: deassert mem_req; on a read, latch valM = mem_rdata; go to DONE.
  - A mem_ack outside WAIT is ignored.
- DONE:
  - out_valid = 1 for exactly one cycle, then IDLE.
  - valM and dmem_error hold their values until the next accept.
- Latency:
  - No-access or error: out_valid 1 cycle after accept.
  - Access: out_valid 1 cycle after the mem_ack cycle; minimum 2 cycles if mem_ack arrives in the first WAIT cycle.
- in_ready is low in WAIT and DONE, so back-to-back accepts are spaced at least 2 cycles apart.
- in_valid and mem_ack are never sampled in the same state, so they cannot conflict.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter resets to 0 on entry to WAIT and increments each WAIT cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES: drop mem_req, set dmem_error = 1, leave valM = 0, go to DONE.
  - If mem_ack and the timeout occur in the same cycle, mem_ack wins.
- Not defined: no counter; WAIT persists until mem_ack or reset.

Test Plan:
- mrmovq, valE = 0x10, memory returns 0xDEADBEEF after 3 cycles -> mem_req = 1 with mem_we = 0 and mem_addr = 0x10 until ack; out_valid the cycle after ack; valM = 0xDEADBEEF; dmem_error = 0.
- call, valE = 0x3F8, valP = 0x2A, immediate ack -> write to 0x3F8 with mem_wdata = 0x2A; out_valid 2 cycles after accept.
- rmmovq, valE = 0x3FC, then popq, valA = 0x400 (MEM_BYTES = 1024) -> no mem_req for either; out_valid 1 cycle after accept; dmem_error = 1 both times.
- opq (icode 6) -> out_valid 1 cycle after accept; valM = 0; mem_req never asserted.
- pushq, valE = 0x100, rst_n low during WAIT, then a stray mem_ack -> all outputs 0 after the reset edge; no out_valid; the next mrmovq completes normally.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, ret, valA = 0x200, no ack -> mem_req drops after 4 WAIT cycles; out_valid with dmem_error = 1 and valM = 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// Y86-64 memory stage: decodes icode, issues one dmem read/write over req/ack, returns valM + dmem_error.
// Latency: 1 cycle accept->out_valid without access or on address error; 1 cycle after the mem_ack cycle otherwise.
// Backpressure: in_ready only in IDLE; mem_req is held until mem_ack (or timeout when MEM_TIMEOUT_EN is defined).
module mem_access_stage #(
  parameter int unsigned MEM_BYTES      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  output logic [63:0] valM,
  output logic        dmem_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Highest legal 8-byte-aligned start address of a quadword access.
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES) - 64'd8;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [63:0] valm_q, valm_d;
  logic        dmem_error_q, dmem_error_d;

  logic        dec_access;
  logic        dec_we;
  logic [63:0] dec_addr;
  logic [63:0] dec_wdata;
  logic        addr_err;
  logic        accept;
  logic        timeout_hit;

  assign accept = in_valid && (state_q == S_IDLE);

  // Decode which access (if any) this instruction performs and its address/data sources.
  always_comb begin
    dec_access = 1'b0;
    dec_we     = 1'b0;
    dec_addr   = valE;
    dec_wdata  = 64'd0;
    case (icode)
      I_RMMOVQ, I_PUSHQ: begin
        dec_access = 1'b1;
        dec_we     = 1'b1;
        dec_wdata  = valA;
      end
      I_CALL: begin
        dec_access = 1'b1;
        dec_we     = 1'b1;
        dec_wdata  = valP;
      end
      I_MRMOVQ: begin
        dec_access = 1'b1;
      end
      I_POPQ, I_RET: begin
        dec_access = 1'b1;
        dec_addr   = valA;
      end
      default: begin
      end
    endcase
  end

  // Misaligned or past-the-end quadwords never reach the memory.
  assign addr_err = (dec_addr[2:0] != 3'b000) || (dec_addr > ADDR_MAX);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count WAIT cycles without an ack; idle value 0 means every WAIT entry starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_WAIT) begin
      cnt_d = '0;
    end else if (!mem_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // An ack in the same cycle as the limit takes priority over the timeout.
  assign timeout_hit = (state_q == S_WAIT) && !mem_ack && (cnt_d == CNT_W'(TIMEOUT_CYCLES));

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without the timeout, WAIT is left only by mem_ack or reset.
  assign timeout_hit = 1'b0;
`endif

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 64'd0;
      mem_wdata_q  <= 64'd0;
      valm_q       <= 64'd0;
      dmem_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      valm_q       <= valm_d;
      dmem_error_q <= dmem_error_d;
    end
  end

  // Next-state logic: skip WAIT when there is nothing legal to send to memory.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (dec_access && !addr_err) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        if (mem_ack || timeout_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: launch the request on accept, close it on ack or timeout.
  always_comb begin
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    valm_d       = valm_q;
    dmem_error_d = dmem_error_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          valm_d       = 64'd0;
          dmem_error_d = dec_access && addr_err;
          if (dec_access && !addr_err) begin
            mem_req_d   = 1'b1;
            mem_we_d    = dec_we;
            mem_addr_d  = dec_addr;
            mem_wdata_d = dec_wdata;
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            valm_d = mem_rdata;
          end
        end else if (timeout_hit) begin
          mem_req_d    = 1'b0;
          dmem_error_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign valM       = valm_q;
  assign dmem_error = dmem_error_q;

endmodule
